// File: rtl/stage_reg_elastic.sv
// stage_reg_elastic: pipeline stage register carrying payload + control; a bubble presents all-zero control.
// Latency: one falling edge from accept to outValid; sustains one entry per cycle.
// Backpressure: SKID=1 registers inReady and parks one entry in a skid slot; SKID=0 derives inReady combinationally.
module stage_reg_elastic #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [CTRL_W-1:0] outCtrl,
    input  logic              flush,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t r_main;
    logic   r_main_vld;
    logic   w_skid_vld;
    logic   w_accept;
    logic   w_consume;
    entry_t w_in;

    assign w_in      = '{ctrl: inCtrl, dat: inData};
    assign w_accept  = inValid & inReady;
    assign w_consume = r_main_vld & outReady;

    generate
        if (SKID != 0) begin : g_skid
            entry_t r_skid;
            logic   r_skid_vld;

            // A full skid slot closes the input, so a drain edge never also takes a new entry.
            assign inReady    = ~r_skid_vld;
            assign w_skid_vld = r_skid_vld;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main     <= '0;
                    r_main_vld <= 1'b0;
                    r_skid     <= '0;
                    r_skid_vld <= 1'b0;
                end else if (flush) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (!r_main_vld || w_consume) begin
                    if (r_skid_vld) begin
                        r_main     <= r_skid;
                        r_main_vld <= 1'b1;
                        r_skid_vld <= 1'b0;
                    end else if (w_accept) begin
                        r_main     <= w_in;
                        r_main_vld <= 1'b1;
                    end else begin
                        r_main_vld <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid     <= w_in;
                    r_skid_vld <= 1'b1;
                end
            end
        end else begin : g_single
            assign inReady    = ~r_main_vld | outReady;
            assign w_skid_vld = 1'b0;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main     <= '0;
                    r_main_vld <= 1'b0;
                end else if (flush) begin
                    r_main_vld <= 1'b0;
                end else if (w_accept) begin
                    r_main     <= w_in;
                    r_main_vld <= 1'b1;
                end else if (w_consume) begin
                    r_main_vld <= 1'b0;
                end
            end
        end
    endgenerate

    assign outValid = r_main_vld;
    assign outData  = r_main.dat;
    assign outCtrl  = r_main_vld ? r_main.ctrl : '0;
    assign count    = {1'b0, r_main_vld} + {1'b0, w_skid_vld};

endmodule

// File: tb/tb_stage_reg_elastic.sv
// Bench for stage_reg_elastic: one SKID=1 and one SKID=0 instance, directed tables plus a random queue-model run.
module tb_stage_reg_elastic;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv1, ir1, ov1, or1, fl1;
    logic [127:0] id1, od1;
    logic [15:0]  ic1, oc1;
    logic [1:0]   cnt1;
    logic         iv0, ir0, ov0, or0, fl0;
    logic [127:0] id0, od0;
    logic [15:0]  ic0, oc0;
    logic [1:0]   cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_reg_elastic #(.DATA_W(128), .CTRL_W(16), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .inValid(iv1), .inReady(ir1), .inData(id1), .inCtrl(ic1),
        .outValid(ov1), .outReady(or1), .outData(od1), .outCtrl(oc1), .flush(fl1), .count(cnt1));

    stage_reg_elastic #(.DATA_W(128), .CTRL_W(16), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .inValid(iv0), .inReady(ir0), .inData(id0), .inCtrl(ic0),
        .outValid(ov0), .outReady(or0), .outData(od0), .outCtrl(oc0), .flush(fl0), .count(cnt0));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         iv;
        logic [127:0] d;
        logic [15:0]  c;
        logic         rr;
        logic         fl;
        logic         ev;
        logic [127:0] ed;
        logic [15:0]  ec;
        logic [1:0]   en;
        logic         er;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic iv, input logic [127:0] d, input logic [15:0] c, input logic rr,
                       input logic fl, input logic ev, input logic [127:0] ed, input logic [15:0] ec,
                       input logic [1:0] en, input logic er);
        vec_t v;
        v = '{iv: iv, d: d, c: c, rr: rr, fl: fl, ev: ev, ed: ed, ec: ec, en: en, er: er};
        vecs.push_back(v);
    endtask

    typedef struct {
        logic [127:0] d;
        logic [15:0]  c;
    } ent_t;
    ent_t         q1[$];
    ent_t         q0[$];
    logic [127:0] last1, last0;

    task automatic step0(input logic iv, input logic [127:0] d, input logic rr, input logic pre_rdy,
                         input logic ev, input logic [127:0] ed, input logic [1:0] en, input int k);
        iv0 = iv; id0 = d; ic0 = 16'h0003; or0 = rr;
        #1;
        chk($sformatf("s0[%0d].inReady", k), ir0, pre_rdy);
        @(posedge clk);
        chk($sformatf("s0[%0d].outValid", k), ov0, ev);
        chk($sformatf("s0[%0d].outData", k), od0, ed);
        chk($sformatf("s0[%0d].outCtrl", k), oc0, ev ? 16'h0003 : 16'h0000);
        chk($sformatf("s0[%0d].count", k), cnt0, en);
    endtask

    initial begin
        logic r1, r0;
        ent_t e;
        rst_n = 1'b0;
        iv1 = 0; id1 = '0; ic1 = '0; or1 = 0; fl1 = 0;
        iv0 = 0; id0 = '0; ic0 = '0; or0 = 0; fl0 = 0;

        // Reset state, then an async pulse in the middle of a held entry.
        #3;
        chk("rst.outValid", ov1, 1'b0);
        chk("rst.outData", od1, 128'h0);
        chk("rst.outCtrl", oc1, 16'h0);
        chk("rst.count", cnt1, 2'd0);
        #4 rst_n = 1'b1;
        #1;
        chk("rst.inReady1", ir1, 1'b1);
        chk("rst.inReady0", ir0, 1'b1);
        @(posedge clk);
        iv1 = 1; id1 = 128'h77; ic1 = 16'h0007; or1 = 0;
        @(posedge clk);
        chk("pre_arst.outValid", ov1, 1'b1);
        chk("pre_arst.outData", od1, 128'h77);
        iv1 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.outValid", ov1, 1'b0);
        chk("arst.outData", od1, 128'h0);
        chk("arst.outCtrl", oc1, 16'h0);
        chk("arst.count", cnt1, 2'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Directed SKID=1 table: expectations are the state after the falling edge.
        add(1, 'h1, 'h101, 1, 0,  1, 'h1, 'h101, 1, 1);
        add(1, 'h2, 'h102, 1, 0,  1, 'h2, 'h102, 1, 1);
        add(1, 'h3, 'h103, 1, 0,  1, 'h3, 'h103, 1, 1);
        add(1, 'h4, 'h104, 1, 0,  1, 'h4, 'h104, 1, 1);
        add(0, 'h0, 'h000, 1, 0,  0, 'h4, 'h000, 0, 1);
        add(1, 'hA, 'h10A, 0, 0,  1, 'hA, 'h10A, 1, 1);
        add(1, 'hB, 'h10B, 0, 0,  1, 'hA, 'h10A, 2, 0);
        add(1, 'hC, 'h10C, 0, 0,  1, 'hA, 'h10A, 2, 0);
        add(1, 'hC, 'h10C, 1, 0,  1, 'hB, 'h10B, 1, 1);
        add(1, 'hC, 'h10C, 1, 0,  1, 'hC, 'h10C, 1, 1);
        add(0, 'h0, 'h000, 1, 0,  0, 'hC, 'h000, 0, 1);
        add(1, 'h10, 'h110, 0, 0, 1, 'h10, 'h110, 1, 1);
        add(1, 'h11, 'h111, 0, 0, 1, 'h10, 'h110, 2, 0);
        add(1, 'h12, 'h112, 0, 1, 0, 'h10, 'h000, 0, 1);
        add(0, 'h0, 'h000, 1, 0,  0, 'h10, 'h000, 0, 1);
        add(1, 'h13, 'h113, 0, 1, 0, 'h10, 'h000, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 'h99, 'hFFFF, 0, 0, 0, 'h10, 'h000, 0, 1);
        add(1, 'h55, 'h0005, 0, 0, 1, 'h55, 'h0005, 1, 1);
        add(0, 'h0, 'hFFFF, 0, 0,   1, 'h55, 'h0005, 1, 1);
        add(0, 'h0, 'hFFFF, 1, 0,   0, 'h55, 'h0000, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            iv1 = vecs[i].iv; id1 = vecs[i].d; ic1 = vecs[i].c; or1 = vecs[i].rr; fl1 = vecs[i].fl;
            @(posedge clk);
            chk($sformatf("vec[%0d].outValid", i), ov1, vecs[i].ev);
            chk($sformatf("vec[%0d].outData", i), od1, vecs[i].ed);
            chk($sformatf("vec[%0d].outCtrl", i), oc1, vecs[i].ec);
            chk($sformatf("vec[%0d].count", i), cnt1, vecs[i].en);
            chk($sformatf("vec[%0d].inReady", i), ir1, vecs[i].er);
        end
        iv1 = 0; fl1 = 0; or1 = 0;

        // SKID=0: outReady 1,0,1 with continuous input, then drain.
        step0(1, 'h20, 1, 1, 1, 'h20, 1, 0);
        step0(1, 'h21, 0, 0, 1, 'h20, 1, 1);
        step0(1, 'h21, 1, 1, 1, 'h21, 1, 2);
        step0(0, 'h0,  0, 0, 1, 'h21, 1, 3);
        step0(0, 'h0,  1, 1, 0, 'h21, 0, 4);
        iv0 = 0; or0 = 0;

        // Random run of both instances against a FIFO-occupancy model.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        q1.delete(); q0.delete();
        last1 = '0; last0 = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            chk("rnd1.outValid", ov1, q1.size() > 0);
            chk("rnd1.outData", od1, last1);
            chk("rnd1.outCtrl", oc1, (q1.size() > 0) ? q1[0].c : 16'h0);
            chk("rnd1.count", cnt1, q1.size());
            chk("rnd0.outValid", ov0, q0.size() > 0);
            chk("rnd0.outData", od0, last0);
            chk("rnd0.outCtrl", oc0, (q0.size() > 0) ? q0[0].c : 16'h0);
            chk("rnd0.count", cnt0, q0.size());

            iv1 = ($urandom_range(0, 9) < 7);
            id1 = {$urandom, $urandom, $urandom, $urandom};
            ic1 = 16'($urandom);
            or1 = ($urandom_range(0, 3) != 0);
            fl1 = ($urandom_range(0, 15) == 0);
            iv0 = ($urandom_range(0, 9) < 7);
            id0 = {$urandom, $urandom, $urandom, $urandom};
            ic0 = 16'($urandom);
            or0 = ($urandom_range(0, 2) != 0);
            fl0 = ($urandom_range(0, 15) == 0);
            #1;
            r1 = (q1.size() < 2);
            r0 = (q0.size() == 0) || or0;
            chk("rnd1.inReady", ir1, r1);
            chk("rnd0.inReady", ir0, r0);

            if (fl1) q1.delete();
            else begin
                if (q1.size() > 0 && or1) void'(q1.pop_front());
                if (iv1 && r1) begin e.d = id1; e.c = ic1; q1.push_back(e); end
            end
            if (q1.size() > 0) last1 = q1[0].d;

            if (fl0) q0.delete();
            else begin
                if (q0.size() > 0 && or0) void'(q0.pop_front());
                if (iv0 && r0) begin e.d = id0; e.c = ic0; q0.push_back(e); end
            end
            if (q0.size() > 0) last0 = q0[0].d;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
